// File: rtl/lockin_demod_harm_pkg.sv
// Shared constants and types for the lock-in demodulator slice.
package lockin_demod_harm_pkg;

  localparam int     LUT_AW  = 10;
  localparam int     REF_AMP = 8191;
  localparam longint FCLK_HZ = 125_000_000;

  // Quadrant of the full-circle phase word (its two MSBs)
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  // First-quadrant table entry k, sampled half an LSB into each step so the
  // folded quadrants reproduce the same magnitudes with no shared zero/peak
  function automatic int quarterSine(input int k, input int aw);
    real v;
    v = real'(REF_AMP) * $sin(2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(4 << aw));
    return $rtoi(v + 0.5);
  endfunction

endpackage

// File: rtl/lockin_demod_harm_if.sv
// Control and data bundle between the demodulator and its user.
interface lockin_demod_harm_if
  import lockin_demod_harm_pkg::*;
#(
  parameter int R  = 14,
  parameter int PW = 32,
  parameter int AW = LUT_AW
);
  logic        [PW-1:0]  freq;
  logic        [2:0]     harm;
  logic        [AW+1:0]  phase_off;
  logic                  phase_clr;
  logic signed [R-1:0]   in;
  logic signed [R-1:0]   ref_sin;
  logic signed [R-1:0]   ref_cos;
  logic signed [2*R-1:0] X;
  logic signed [2*R-1:0] Y;
  logic                  ref_wrap;

  modport master (
    output freq, harm, phase_off, phase_clr, in,
    input  ref_sin, ref_cos, X, Y, ref_wrap
  );

  modport slave (
    input  freq, harm, phase_off, phase_clr, in,
    output ref_sin, ref_cos, X, Y, ref_wrap
  );
endinterface

// File: rtl/lockin_demod_harm_sincos_lut.sv
// Quadrant-folded sine/cosine ROM with registered outputs. One table is read
// at address a and at ~a, which maps onto both ports of a single block RAM.
module sincos_lut
  import lockin_demod_harm_pkg::*;
#(
  parameter int AW = LUT_AW,
  parameter int R  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW+1:0]       ph_i,
  input  logic                harmZero_i,
  input  logic                phVld_i,
  output logic signed [R-1:0] refSin_o,
  output logic signed [R-1:0] refCos_o
);

  logic        [R-2:0]  romW [0:(1<<AW)-1];
  quad_e                quad;
  logic        [AW-1:0] addr;
  logic signed [R-1:0]  tA;
  logic signed [R-1:0]  tN;
  logic signed [R-1:0]  sin_d, sin_q;
  logic signed [R-1:0]  cos_d, cos_q;

  for (genvar k = 0; k < (1 << AW); k++) begin : g_rom
    assign romW[k] = (R-1)'(quarterSine(k, AW));
  end

  assign quad = quad_e'(ph_i[AW+1:AW]);
  assign addr = ph_i[AW-1:0];
  assign tA   = $signed({1'b0, romW[addr]});
  assign tN   = $signed({1'b0, romW[~addr]});

  // Unfold the quarter wave; a DC reference replaces the table when harm is 0
  always_comb begin
    sin_d = '0;
    cos_d = '0;
    if (harmZero_i) begin
      sin_d = '0;
      cos_d = R'(REF_AMP);
    end else begin
      case (quad)
        QUAD_0: begin sin_d =  tA; cos_d =  tN; end
        QUAD_1: begin sin_d =  tN; cos_d = -tA; end
        QUAD_2: begin sin_d = -tA; cos_d = -tN; end
        QUAD_3: begin sin_d = -tN; cos_d =  tA; end
        default: begin sin_d = '0; cos_d = '0; end
      endcase
    end
  end

  // Register the reference; hold zero until the phase stage carries real data
  always_ff @(posedge clk) begin
    if (rst || !phVld_i) begin
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end

  assign refSin_o = sin_q;
  assign refCos_o = cos_q;

endmodule

// File: rtl/lockin_demod_harm.sv
// Lock-in demodulator: NCO, harmonic phase scaling, sin/cos reference and the
// two signal-by-reference products feeding the downstream low-pass filters.
module lockin_demod_harm
  import lockin_demod_harm_pkg::*;
#(
  parameter int R  = 14,
  parameter int PW = 32,
  parameter int AW = LUT_AW
) (
  input logic                clk,
  input logic                rst,
  lockin_demod_harm_if.slave bus
);

  logic        [PW-1:0]  acc_q, acc_d;
  logic                  wrap_q, wrap_d;
  logic        [AW+1:0]  accTop;
  logic        [AW+1:0]  ph_q, ph_d;
  logic                  harmZero_q;
  logic                  phVld_q;
  logic signed [R-1:0]   inR_q;
  logic signed [2*R-1:0] x_q, x_d;
  logic signed [2*R-1:0] y_q, y_d;
  logic signed [R-1:0]   refSin;
  logic signed [R-1:0]   refCos;

  // Fundamental accumulator; the add's carry marks one reference period
  always_comb begin
    {wrap_d, acc_d} = {1'b0, acc_q} + {1'b0, bus.freq};
    if (bus.phase_clr) begin
      acc_d  = '0;
      wrap_d = 1'b0;
    end
  end

  // Harmonic scaling truncates to the circle, so phase wraps for free
  assign accTop = acc_q[PW-1:PW-AW-2];
  always_comb begin
    ph_d = accTop * {{(AW-1){1'b0}}, bus.harm} + bus.phase_off;
  end

  // Full-precision products; the reference never reaches -2^(R-1), so no overflow
  always_comb begin
    x_d = (2*R)'(inR_q) * (2*R)'(refSin);
    y_d = (2*R)'(inR_q) * (2*R)'(refCos);
  end

  // Accumulator and wrap flag
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      wrap_q <= wrap_d;
    end
  end

  // Phase stage; harm is latched alongside the phase it scaled
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q       <= '0;
      harmZero_q <= 1'b0;
      phVld_q    <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      harmZero_q <= (bus.harm == 3'd0);
      phVld_q    <= 1'b1;
    end
  end

  // Input register and product registers
  always_ff @(posedge clk) begin
    if (rst) begin
      inR_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      inR_q <= bus.in;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  sincos_lut #(.AW(AW), .R(R)) uLut (
    .clk        (clk),
    .rst        (rst),
    .ph_i       (ph_q),
    .harmZero_i (harmZero_q),
    .phVld_i    (phVld_q),
    .refSin_o   (refSin),
    .refCos_o   (refCos)
  );

  assign bus.ref_sin  = refSin;
  assign bus.ref_cos  = refCos;
  assign bus.X        = x_q;
  assign bus.Y        = y_q;
  assign bus.ref_wrap = wrap_q;

endmodule

// File: tb/tb_lockin_demod_harm.sv
// Scoreboarded bench for the lock-in demodulator: a cycle model predicts every
// output word when the inputs are driven, and each scenario adds its own checks.
module tb_lockin_demod_harm;
  import lockin_demod_harm_pkg::*;

  localparam real PI = 3.14159265358979323846;

  typedef struct packed {
    logic signed [27:0] x;
    logic signed [27:0] y;
    logic signed [13:0] rs;
    logic signed [13:0] rc;
    logic               w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nFail = 0;
  int   cyc = 0;
  exp_t sbq[$];

  logic [31:0] mAcc = '0;
  logic        mWrap = 1'b0;
  logic [11:0] mPh = '0;
  logic        mHz = 1'b0;
  logic        mVld = 1'b0;
  int          mRs = 0, mRc = 0, mInR = 0, mX = 0, mY = 0;

  always #5 clk = ~clk;

  lockin_demod_harm_if bus ();

  lockin_demod_harm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int roundAway(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic int expSin(input int ph);
    return roundAway(8191.0 * $sin(2.0 * PI * (real'(ph) + 0.5) / 4096.0));
  endfunction

  function automatic int expCos(input int ph);
    return roundAway(8191.0 * $cos(2.0 * PI * (real'(ph) + 0.5) / 4096.0));
  endfunction

  // Advance the model from the currently driven inputs, queue its prediction,
  // then let the DUT take the same clock edge
  task automatic tick();
    exp_t        e;
    logic [32:0] s;
    if (rst) begin
      mAcc = '0; mWrap = 1'b0; mPh = '0; mHz = 1'b0; mVld = 1'b0;
      mRs = 0; mRc = 0; mInR = 0; mX = 0; mY = 0;
    end else begin
      mX   = mInR * mRs;
      mY   = mInR * mRc;
      mInR = int'(bus.in);
      if (!mVld) begin
        mRs = 0; mRc = 0;
      end else if (mHz) begin
        mRs = 0; mRc = 8191;
      end else begin
        mRs = expSin(int'(mPh));
        mRc = expCos(int'(mPh));
      end
      mPh  = mAcc[31:20] * {9'd0, bus.harm} + bus.phase_off;
      mHz  = (bus.harm == 3'd0);
      mVld = 1'b1;
      if (bus.phase_clr) begin
        mAcc = '0; mWrap = 1'b0;
      end else begin
        s = {1'b0, mAcc} + {1'b0, bus.freq};
        mAcc = s[31:0]; mWrap = s[32];
      end
    end
    e.x = 28'(mX); e.y = 28'(mY); e.rs = 14'(mRs); e.rc = 14'(mRc); e.w = mWrap;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    bus.in = 14'sd1000; bus.freq = 32'h1000_0000; bus.harm = 3'd1;
    bus.phase_off = '0; bus.phase_clr = 1'b0;
    repeat (4) begin
      tick();
      e = sbq.pop_front();
      nChecks++;
      if ({bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap} !== e) begin
        nFail++;
        $display("[TB] FAIL sb_reset cyc=%0d got X=%0d Y=%0d s=%0d c=%0d w=%0b want X=%0d Y=%0d s=%0d c=%0d w=%0b",
                 cyc, bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap, e.x, e.y, e.rs, e.rc, e.w);
      end
      nChecks++;
      if (bus.X !== 28'sd0 || bus.Y !== 28'sd0 || bus.ref_sin !== 14'sd0 ||
          bus.ref_cos !== 14'sd0 || bus.ref_wrap !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL reset_zero cyc=%0d got X=%0d Y=%0d s=%0d c=%0d w=%0b want all 0",
                 cyc, bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap);
      end
    end
  endtask

  task automatic test_fundamental();
    exp_t e;
    int   sumX = 0, maxX = -(1 << 30), lastWrap = 0, nWrap = 0, badPer = 0;
    int   rsHist[1:48];
    rst = 1'b0;
    bus.in = 14'sd8191;
    for (int i = 1; i <= 48; i++) begin
      tick();
      e = sbq.pop_front();
      nChecks++;
      if ({bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap} !== e) begin
        nFail++;
        $display("[TB] FAIL sb_fund cyc=%0d got X=%0d Y=%0d s=%0d c=%0d w=%0b want X=%0d Y=%0d s=%0d c=%0d w=%0b",
                 cyc, bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap, e.x, e.y, e.rs, e.rc, e.w);
      end
      rsHist[i] = int'(bus.ref_sin);
      if (i >= 17 && i <= 32) begin
        sumX += int'(bus.X);
        if (int'(bus.X) > maxX) maxX = int'(bus.X);
      end
      if (bus.ref_wrap === 1'b1) begin
        nChecks++;
        if (i - lastWrap != 16) begin
          nFail++;
          $display("[TB] FAIL wrap_period cyc=%0d got interval %0d want 16", cyc, i - lastWrap);
        end
        lastWrap = i;
        nWrap++;
      end
    end
    for (int i = 17; i <= 32; i++) if (rsHist[i] != rsHist[i+16]) badPer++;
    nChecks++;
    if (nWrap != 3) begin
      nFail++;
      $display("[TB] FAIL wrap_count got %0d want 3", nWrap);
    end
    nChecks++;
    if (badPer != 0) begin
      nFail++;
      $display("[TB] FAIL sin_period16 got %0d mismatching samples want 0", badPer);
    end
    nChecks++;
    if (sumX > 16 || sumX < -16) begin
      nFail++;
      $display("[TB] FAIL x_mean_fund got sum %0d want |sum|<=16", sumX);
    end
    nChecks++;
    if (maxX > 67092482 || maxX < 67092480) begin
      nFail++;
      $display("[TB] FAIL x_max got %0d want 67092481 +/-1", maxX);
    end
  endtask

  task automatic test_harmonic();
    exp_t e;
    int   sumX = 0, badPer = 0;
    int   rsHist[1:36];
    bus.harm = 3'd3;
    for (int i = 1; i <= 36; i++) begin
      tick();
      e = sbq.pop_front();
      nChecks++;
      if ({bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap} !== e) begin
        nFail++;
        $display("[TB] FAIL sb_harm3 cyc=%0d got X=%0d Y=%0d s=%0d c=%0d w=%0b want X=%0d Y=%0d s=%0d c=%0d w=%0b",
                 cyc, bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap, e.x, e.y, e.rs, e.rc, e.w);
      end
      rsHist[i] = int'(bus.ref_sin);
      if (i >= 5 && i <= 20) sumX += int'(bus.X);
    end
    for (int i = 5; i <= 20; i++) if (rsHist[i] != rsHist[i+16]) badPer++;
    nChecks++;
    if (sumX > 16 || sumX < -16) begin
      nFail++;
      $display("[TB] FAIL x_sum_harm3 got %0d want |sum|<=16", sumX);
    end
    nChecks++;
    if (badPer != 0) begin
      nFail++;
      $display("[TB] FAIL sin_period_harm3 got %0d mismatching samples want 0", badPer);
    end
    bus.harm = 3'd0;
    repeat (4) begin
      tick();
      e = sbq.pop_front();
      nChecks++;
      if ({bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap} !== e) begin
        nFail++;
        $display("[TB] FAIL sb_harm0 cyc=%0d got X=%0d Y=%0d s=%0d c=%0d w=%0b want X=%0d Y=%0d s=%0d c=%0d w=%0b",
                 cyc, bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap, e.x, e.y, e.rs, e.rc, e.w);
      end
    end
    nChecks++;
    if (bus.ref_sin !== 14'sd0 || bus.ref_cos !== 14'sd8191 || bus.Y !== 28'sd67092481 || bus.X !== 28'sd0) begin
      nFail++;
      $display("[TB] FAIL dc_ref got s=%0d c=%0d X=%0d Y=%0d want s=0 c=8191 X=0 Y=67092481",
               bus.ref_sin, bus.ref_cos, bus.X, bus.Y);
    end
  endtask

  task automatic test_phase_clr();
    exp_t e;
    int   offs[4]  = '{0, 1024, 2048, 3072};
    int   wantS[4] = '{6, 8191, -6, -8191};
    int   wantC[4] = '{8191, -6, -8191, 6};
    bus.harm = 3'd1;
    bus.phase_clr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.phase_off = 12'(offs[k]);
      repeat (3) begin
        tick();
        e = sbq.pop_front();
        nChecks++;
        if ({bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap} !== e) begin
          nFail++;
          $display("[TB] FAIL sb_clr cyc=%0d got X=%0d Y=%0d s=%0d c=%0d w=%0b want X=%0d Y=%0d s=%0d c=%0d w=%0b",
                   cyc, bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap, e.x, e.y, e.rs, e.rc, e.w);
        end
        nChecks++;
        if (bus.ref_wrap !== 1'b0) begin
          nFail++;
          $display("[TB] FAIL clr_no_wrap cyc=%0d got %0b want 0", cyc, bus.ref_wrap);
        end
      end
      nChecks++;
      if (int'(bus.ref_sin) != wantS[k] || int'(bus.ref_cos) != wantC[k]) begin
        nFail++;
        $display("[TB] FAIL phase_off_%0d got s=%0d c=%0d want s=%0d c=%0d",
                 offs[k], bus.ref_sin, bus.ref_cos, wantS[k], wantC[k]);
      end
    end
  endtask

  task automatic test_extremes();
    exp_t e;
    bus.phase_off = 12'd3072;
    bus.in = -14'sd8192;
    for (int i = 1; i <= 5; i++) begin
      if (i == 4) bus.in = 14'sd8191;
      tick();
      e = sbq.pop_front();
      nChecks++;
      if ({bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap} !== e) begin
        nFail++;
        $display("[TB] FAIL sb_ext cyc=%0d got X=%0d Y=%0d s=%0d c=%0d w=%0b want X=%0d Y=%0d s=%0d c=%0d w=%0b",
                 cyc, bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap, e.x, e.y, e.rs, e.rc, e.w);
      end
      if (i == 3) begin
        nChecks++;
        if (bus.X !== 28'sd67100672) begin
          nFail++;
          $display("[TB] FAIL x_neg_full got %0d want 67100672", bus.X);
        end
      end
      if (i == 5) begin
        nChecks++;
        if (bus.X !== -28'sd67092481) begin
          nFail++;
          $display("[TB] FAIL x_pos_full got %0d want -67092481", bus.X);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   firstWrap = 0;
    bus.phase_clr = 1'b0; bus.phase_off = '0; bus.harm = 3'd1;
    bus.freq = 32'h0400_0000; bus.in = 14'sd5000;
    for (int i = 1; i <= 101; i++) begin
      rst = (i == 21);
      tick();
      e = sbq.pop_front();
      nChecks++;
      if ({bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap} !== e) begin
        nFail++;
        $display("[TB] FAIL sb_rstmid cyc=%0d got X=%0d Y=%0d s=%0d c=%0d w=%0b want X=%0d Y=%0d s=%0d c=%0d w=%0b",
                 cyc, bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap, e.x, e.y, e.rs, e.rc, e.w);
      end
      if (i == 21) begin
        nChecks++;
        if (bus.X !== 28'sd0 || bus.Y !== 28'sd0 || bus.ref_sin !== 14'sd0 ||
            bus.ref_cos !== 14'sd0 || bus.ref_wrap !== 1'b0) begin
          nFail++;
          $display("[TB] FAIL rst_mid_zero got X=%0d Y=%0d s=%0d c=%0d w=%0b want all 0",
                   bus.X, bus.Y, bus.ref_sin, bus.ref_cos, bus.ref_wrap);
        end
      end
      if (i == 22 || i == 23) begin
        nChecks++;
        if (bus.X !== 28'sd0 || bus.Y !== 28'sd0) begin
          nFail++;
          $display("[TB] FAIL resume_early clk=%0d got X=%0d Y=%0d want 0", i - 21, bus.X, bus.Y);
        end
      end
      if (i == 24) begin
        nChecks++;
        if (bus.X === 28'sd0 || bus.Y === 28'sd0) begin
          nFail++;
          $display("[TB] FAIL resume_3clk got X=%0d Y=%0d want both nonzero", bus.X, bus.Y);
        end
      end
      if (i > 21 && firstWrap == 0 && bus.ref_wrap === 1'b1) firstWrap = i - 21;
    end
    nChecks++;
    if (firstWrap != 64) begin
      nFail++;
      $display("[TB] FAIL first_wrap got %0d clk want 64", firstWrap);
    end
  endtask

  initial begin
    test_reset();
    test_fundamental();
    test_harmonic();
    test_phase_clr();
    test_extremes();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  // Hard stop in case the run ever stalls
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
